twiddle_mul_8: RTL and testbench
================================

// Module: twiddle_mul_8
// PURPOSE
//  Streaming complex twiddle multiplier for the 8-point FFT/IFFT datapath: reads the
//  twiddle_8 ROM, conjugates the weight for the inverse direction, multiplies one sample per
//  cycle, then rounds and saturates. Sits between butterfly stages. Two-stage pipeline with
//  valid/ready backpressure; flags the last sample of each frame.
// PARAMETERS
//  DATA_WIDTH  8   signed width of sample re/im in and out
//  TW_WIDTH    4   signed width of twiddle re/im (ROM word; +7 = unity)
//  FFT_SIZE    8   transform size; twiddle index range 0..FFT_SIZE-1
//  FRAME_LEN   4   accepted samples per frame (drives out_last)
// PORTS
//  clk         in   1              single clock, rising edge
//  rst_n       in   1              asynchronous, active-low reset
//  in_valid    in   1              input sample valid
//  in_ready    out  1              block can accept input this cycle
//  in_re       in   DATA_WIDTH     sample real, two's complement
//  in_im       in   DATA_WIDTH     sample imag, two's complement
//  in_k        in   clog2(FFT_SIZE) twiddle index k (W = e^{-j2pi k/8})
//  in_inverse  in   1              1 = IFFT direction, use conj(W)
//  in_clear    in   1              sync clear of the frame counter
//  out_valid   out  1              output sample valid
//  out_ready   in   1              downstream accepts output
//  out_re      out  DATA_WIDTH     product real, rounded, saturated
//  out_im      out  DATA_WIDTH     product imag, rounded, saturated
//  out_last    out  1              output is last of a FRAME_LEN frame
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, out_re=out_im=0, out_last=0, both stage valids=0,
//    frame counter=0. in_ready=1 one cycle after rst_n deasserts. Any in-flight data is dropped.
//  - Transfer: in handshake = in_valid&in_ready; out handshake = out_valid&out_ready.
//  - Stage A captures in_re/in_im, the ROM word at {1'b0,in_k} with im negated when
//    in_inverse=1, and the frame-last flag. Stage B captures the product.
//  - Latency: 2 cycles from input handshake to out_valid with no stall; one sample/cycle.
//  - Stall: b_adv = !b_valid | out_ready; a_adv = !a_valid | b_adv; in_ready = a_adv
//    (combinational from out_ready). While stalled, out_* hold stable; no drop, no duplicate.
//  - Conjugate: -(-2^(TW_WIDTH-1)) saturates to 2^(TW_WIDTH-1)-1 (-8 -> +7).
//  - Arithmetic, full precision (DATA_WIDTH+TW_WIDTH+1 bits):
//    pr = xr*wr - xi*wi;  pi = xr*wi + xi*wr.
//    Scale: out = (p + 2^(TW_WIDTH-2)) >>> (TW_WIDTH-1), arithmetic shift, round half up.
//    Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Unity weight +7 gives gain 0.875.
//  - Frame counter: increments on each input handshake, wraps FRAME_LEN-1 -> 0.
//    The sample accepted at count FRAME_LEN-1 carries last=1 to out_last.
//    in_clear forces the counter to 0. If in_clear and a handshake occur in the same cycle,
//    the handshake sample is counted as index 0 (last=0 unless FRAME_LEN=1), and the counter
//    is 1 after that cycle.
//  - in_k >= FFT_SIZE cannot occur (index width bounds it). ROM entries 8..15 are unreachable.
//  - The block has no internal FSM beyond the per-stage valids and the counter.
// STRUCTURE
//  - Shared package fft_pkg: DATA_WIDTH, TW_WIDTH, FFT_SIZE constants; complex sample
//    typedef {re,im}; sat/round helper function reused by the butterfly.
//  - One sub-module: twiddle_8 (existing ROM), instantiated with address = {1'b0,in_k}.
//  - The multiply/round/saturate logic stays inline in this module.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream with 2 samples in flight -> out_valid=0 immediately;
//    no stale output after release.
//  2 Fwd k=0: in=(64,0) -> out=(56,0) exactly 2 cycles later.
//  3 Fwd k=2: in=(64,0) -> (0,-64). Same with in_inverse=1 -> (0,+56), conj saturation.
//  4 Saturation: in=(127,127), k=1, fwd -> re 1274>>3 = 159 -> 127, im=0.
//    in=(-128,-128), k=1 -> (-128,0).
//  5 Backpressure: 6 back-to-back inputs, out_ready low cycles 3..5 -> in_ready drops;
//    outputs hold; all 6 arrive in order, none lost or repeated.
//  6 Frame: 8 inputs -> out_last on outputs 4 and 8. in_clear with input 2 -> out_last on
//    output 5 instead.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, sample type and rounding helpers for the 8-point FFT datapath.
// Reused by the butterfly stages and the twiddle multiplier.
package fft_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int TW_WIDTH   = 4;
    localparam int FFT_SIZE   = 8;
    localparam int FRAME_LEN  = 4;
    localparam int K_WIDTH    = $clog2(FFT_SIZE);
    localparam int PROD_WIDTH = DATA_WIDTH + TW_WIDTH + 1;

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } cplx_t;

    // Scale a full-precision product back to sample width: round half up, then clamp.
    function automatic logic signed [DATA_WIDTH-1:0] round_sat(
        input logic signed [PROD_WIDTH-1:0] p
    );
        logic signed [PROD_WIDTH:0] r;
        logic signed [PROD_WIDTH:0] hi;
        logic signed [PROD_WIDTH:0] lo;
        hi = (PROD_WIDTH+1)'(2 ** (DATA_WIDTH-1) - 1);
        lo = (PROD_WIDTH+1)'(-(2 ** (DATA_WIDTH-1)));
        r  = {p[PROD_WIDTH-1], p} + (PROD_WIDTH+1)'(2 ** (TW_WIDTH-2));
        r  = r >>> (TW_WIDTH-1);
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r[DATA_WIDTH-1:0];
    endfunction

    // Negate a twiddle component; the most negative code has no positive twin.
    function automatic logic signed [TW_WIDTH-1:0] conj_sat(
        input logic signed [TW_WIDTH-1:0] w
    );
        logic signed [TW_WIDTH-1:0] most_neg;
        most_neg = {1'b1, {(TW_WIDTH-1){1'b0}}};
        if (w == most_neg) begin
            return ~most_neg;
        end
        return -w;
    endfunction

endpackage

// File: rtl/twiddle_8.sv
// Twiddle ROM for the 8-point transform, W^k = e^{-j2pi k/8}, 4-bit signed re/im.
// Positive unity is +7; negative unity uses the full-range code -8.
module twiddle_8
    import fft_pkg::*;
(
    input  logic        [3:0]          addr_i,
    output logic signed [TW_WIDTH-1:0] w_re_o,
    output logic signed [TW_WIDTH-1:0] w_im_o
);

    localparam logic signed [TW_WIDTH-1:0] P7 = 4'sb0111;
    localparam logic signed [TW_WIDTH-1:0] P5 = 4'sb0101;
    localparam logic signed [TW_WIDTH-1:0] Z0 = 4'sb0000;
    localparam logic signed [TW_WIDTH-1:0] N5 = 4'sb1011;
    localparam logic signed [TW_WIDTH-1:0] N8 = 4'sb1000;

    always_comb begin
        w_re_o = Z0;
        w_im_o = Z0;
        case (addr_i)
            4'd0: begin w_re_o = P7; w_im_o = Z0; end
            4'd1: begin w_re_o = P5; w_im_o = N5; end
            4'd2: begin w_re_o = Z0; w_im_o = N8; end
            4'd3: begin w_re_o = N5; w_im_o = N5; end
            4'd4: begin w_re_o = N8; w_im_o = Z0; end
            4'd5: begin w_re_o = N5; w_im_o = P5; end
            4'd6: begin w_re_o = Z0; w_im_o = P7; end
            4'd7: begin w_re_o = P5; w_im_o = P5; end
            default: begin w_re_o = Z0; w_im_o = Z0; end
        endcase
    end

endmodule

// File: rtl/twiddle_mul_8.sv
// Streaming complex twiddle multiplier: stage A latches sample + weight, stage B holds
// the rounded, saturated product. Valid/ready on both sides, frame-last tagging.
module twiddle_mul_8
    import fft_pkg::*;
#(
    parameter int FRAME_LEN_P = FRAME_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_re,
    input  logic [DATA_WIDTH-1:0] in_im,
    input  logic [K_WIDTH-1:0]    in_k,
    input  logic                  in_inverse,
    input  logic                  in_clear,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_re,
    output logic [DATA_WIDTH-1:0] out_im,
    output logic                  out_last
);

    localparam int CNT_W = (FRAME_LEN_P > 1) ? $clog2(FRAME_LEN_P) : 1;

    logic                       rdy_en_q;
    logic                       a_valid_q;
    logic                       a_last_q;
    cplx_t                      a_x_q;
    logic signed [TW_WIDTH-1:0] a_wr_q;
    logic signed [TW_WIDTH-1:0] a_wi_q;
    logic                       b_valid_q;
    logic                       b_last_q;
    cplx_t                      b_y_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [CNT_W-1:0]           cnt_d;

    logic                       b_adv;
    logic                       a_adv;
    logic                       in_hs;
    logic [CNT_W-1:0]           idx;
    logic                       in_last;
    logic signed [TW_WIDTH-1:0] rom_re;
    logic signed [TW_WIDTH-1:0] rom_im;
    logic signed [TW_WIDTH-1:0] w_im_sel;
    logic signed [PROD_WIDTH-1:0] pr;
    logic signed [PROD_WIDTH-1:0] pi;

    twiddle_8 u_rom (
        .addr_i ({1'b0, in_k}),
        .w_re_o (rom_re),
        .w_im_o (rom_im)
    );

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready depends combinationally on out_ready so a drained pipe never bubbles.
    always_comb begin
        b_adv    = !b_valid_q || out_ready;
        a_adv    = !a_valid_q || b_adv;
        in_ready = a_adv && rdy_en_q;
        in_hs    = in_valid && in_ready;
        w_im_sel = in_inverse ? conj_sat(rom_im) : rom_im;
    end

    // A clear in the same cycle as a handshake makes that sample index 0 of a new frame.
    always_comb begin
        idx     = in_clear ? '0 : cnt_q;
        in_last = (idx == CNT_W'(FRAME_LEN_P - 1));
        cnt_d   = cnt_q;
        if (in_hs) begin
            cnt_d = in_last ? '0 : idx + 1'b1;
        end else if (in_clear) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        pr = PROD_WIDTH'(a_x_q.re) * PROD_WIDTH'(a_wr_q)
           - PROD_WIDTH'(a_x_q.im) * PROD_WIDTH'(a_wi_q);
        pi = PROD_WIDTH'(a_x_q.re) * PROD_WIDTH'(a_wi_q)
           + PROD_WIDTH'(a_x_q.im) * PROD_WIDTH'(a_wr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q  <= 1'b0;
            a_valid_q <= 1'b0;
            a_last_q  <= 1'b0;
            a_x_q     <= '0;
            a_wr_q    <= '0;
            a_wi_q    <= '0;
            b_valid_q <= 1'b0;
            b_last_q  <= 1'b0;
            b_y_q     <= '0;
            cnt_q     <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            cnt_q    <= cnt_d;
            if (a_adv) begin
                a_valid_q <= in_hs;
                if (in_hs) begin
                    a_x_q.re <= in_re;
                    a_x_q.im <= in_im;
                    a_wr_q   <= rom_re;
                    a_wi_q   <= w_im_sel;
                    a_last_q <= in_last;
                end
            end
            if (b_adv) begin
                b_valid_q <= a_valid_q;
                if (a_valid_q) begin
                    b_y_q.re <= round_sat(pr);
                    b_y_q.im <= round_sat(pi);
                    b_last_q <= a_last_q;
                end
            end
        end
    end

    assign out_valid = b_valid_q;
    assign out_re    = b_y_q.re;
    assign out_im    = b_y_q.im;
    assign out_last  = b_valid_q && b_last_q;

endmodule

// File: tb/tb_twiddle_mul_8.sv
// Directed bench for twiddle_mul_8: reset, weight/rounding/saturation vectors,
// backpressure ordering and frame-last tagging with and without a clear.
module tb_twiddle_mul_8;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_re;
    logic [7:0] in_im;
    logic [2:0] in_k;
    logic       in_inverse;
    logic       in_clear;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_re;
    logic [7:0] out_im;
    logic       out_last;

    int checks;
    int passes;
    int fails;

    int rx_re[16];
    int rx_im[16];
    int rx_last[16];
    int rx_n;
    int saw_stall;

    twiddle_mul_8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_re      (in_re),
        .in_im      (in_im),
        .in_k       (in_k),
        .in_inverse (in_inverse),
        .in_clear   (in_clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] got, input int exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One isolated sample with out_ready high; result must appear exactly two edges later.
    task automatic run_one(input string tag, input int re, input int im, input int k,
                           input bit inv, input int exp_re, input int exp_im);
        in_valid   = 1'b1;
        in_re      = 8'(re);
        in_im      = 8'(im);
        in_k       = 3'(k);
        in_inverse = inv;
        tick();
        in_valid = 1'b0;
        check({tag, "_early"}, out_valid, 0);
        tick();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_re"}, $signed(out_re), exp_re);
        check({tag, "_im"}, $signed(out_im), exp_im);
        tick();
    endtask

    // Stream n samples (8n,-8n) at k=0, holding out_ready low for cycles lo..hi.
    task automatic stream(input int n, input int clr_idx, input int lo, input int hi);
        int sent;
        int cyc;
        bit in_hs;
        bit hold_v;
        int hold_re;
        int hold_im;
        sent      = 0;
        cyc       = 0;
        hold_v    = 0;
        hold_re   = 0;
        hold_im   = 0;
        rx_n      = 0;
        saw_stall = 0;
        while (rx_n < n && cyc < 40) begin
            out_ready = !(cyc >= lo && cyc <= hi);
            if (sent < n) begin
                in_valid   = 1'b1;
                in_re      = 8'(8 * (sent + 1));
                in_im      = 8'(-8 * (sent + 1));
                in_k       = 3'd0;
                in_inverse = 1'b0;
                in_clear   = (sent == clr_idx);
            end else begin
                in_valid = 1'b0;
                in_clear = 1'b0;
            end
            #1;
            if (hold_v) begin
                check($sformatf("hold_v_c%0d", cyc), out_valid, 1);
                check($sformatf("hold_re_c%0d", cyc), $signed(out_re), hold_re);
                check($sformatf("hold_im_c%0d", cyc), $signed(out_im), hold_im);
            end
            if (!in_ready) saw_stall = 1;
            in_hs = in_valid && in_ready;
            if (out_valid && out_ready) begin
                rx_re[rx_n]   = $signed(out_re);
                rx_im[rx_n]   = $signed(out_im);
                rx_last[rx_n] = out_last;
                rx_n++;
            end
            hold_v  = out_valid && !out_ready;
            hold_re = $signed(out_re);
            hold_im = $signed(out_im);
            tick();
            if (in_hs) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        in_clear  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        checks     = 0;
        passes     = 0;
        fails      = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_re      = '0;
        in_im      = '0;
        in_k       = '0;
        in_inverse = 1'b0;
        in_clear   = 1'b0;
        out_ready  = 1'b1;

        #3;
        check("rst_valid", out_valid, 0);
        check("rst_re", out_re, 0);
        check("rst_im", out_im, 0);
        check("rst_last", out_last, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_ready", in_ready, 1);

        run_one("k0_fwd", 64, 0, 0, 1'b0, 56, 0);
        run_one("k2_fwd", 64, 0, 2, 1'b0, 0, -64);
        run_one("k2_inv", 64, 0, 2, 1'b1, 0, 56);
        run_one("k1_satp", 127, 127, 1, 1'b0, 127, 0);
        run_one("k1_satn", -128, -128, 1, 1'b0, -128, 0);
        run_one("k3_inv_rnd", 16, 8, 3, 1'b1, -15, 5);
        run_one("k4_rnd", 3, 0, 4, 1'b0, -3, 0);

        // Reset mid-stream with two samples in flight.
        in_valid = 1'b1; in_re = 8'd64; in_im = 8'd0; in_k = 3'd0; in_inverse = 1'b0;
        tick();
        in_re = 8'd32;
        tick();
        in_valid = 1'b0;
        check("mid_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_re", out_re, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("mid_stale_%0d", i), out_valid, 0);
        end
        check("mid_ready", in_ready, 1);

        // Backpressure: 6 samples, out_ready low on cycles 3..5.
        stream(6, -1, 3, 5);
        check("bp_count", rx_n, 6);
        check("bp_stall_seen", saw_stall, 1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_re%0d", i), rx_re[i], 7 * (i + 1));
            check($sformatf("bp_im%0d", i), rx_im[i], -7 * (i + 1));
        end

        // Frame tagging from a clean counter.
        do_reset();
        stream(8, -1, 100, 100);
        check("fr_count", rx_n, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("fr_last%0d", i), rx_last[i], (i == 3 || i == 7) ? 1 : 0);
        end

        // Clear presented with input 2 restarts the frame there.
        do_reset();
        stream(8, 1, 100, 100);
        check("clr_count", rx_n, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("clr_last%0d", i), rx_last[i], (i == 4) ? 1 : 0);
            check($sformatf("clr_re%0d", i), rx_re[i], 7 * (i + 1));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
